// File: rtl/start_line_search_gen2.sv
// start_line_search_gen2: scans BRAM rows for the first non-empty mask row,
// then copies it to WR_BASE. Optional row wrap-around: `SLS_ROW_WRAP_EN.
module start_line_search_gen2 #(
  parameter int ROW_BITS = 512,
  parameter int WORD_W   = 32,
  parameter int ADDR_W   = 13,
  parameter int ROW_W    = 9,
  parameter int NUM_ROWS = 512,
  parameter logic [ADDR_W-1:0] WR_BASE = ADDR_W'('h1000)
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_trig,
  output logic                o_done,
  input  logic [ROW_W-1:0]    i_start_row_num,
  input  logic                i_dir,
  output logic [ADDR_W-1:0]   o_rd_from_bram_addr,
  input  logic [WORD_W-1:0]   i_rd_from_bram_data,
  output logic                o_rd_from_bram_trig,
  input  logic                i_rd_from_bram_done,
  output logic [ADDR_W-1:0]   o_wr_to_bram_addr,
  output logic [WORD_W-1:0]   o_wr_to_bram_data,
  output logic                o_wr_to_bram_trig,
  input  logic                i_wr_to_bram_done,
  output logic [ROW_BITS-1:0] o_row_mask,
  output logic [ROW_W-1:0]    o_found_row,
  output logic                o_found
);

  localparam int WPR  = ROW_BITS / WORD_W;
  localparam int WC_W = (WPR > 1) ? $clog2(WPR) : 1;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, CHECK, WR_REQ, WR_WAIT, DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ROW_W-1:0]    r_row;
  logic [ROW_W-1:0]    w_row_nxt;
  logic                r_dir;
  logic [WC_W-1:0]     r_word;
  logic [ROW_BITS-1:0] r_buf;
  logic                w_word_last;
  logic                w_row_last;
  logic                w_nonempty;
  logic                w_start_bad;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [ADDR_W-1:0]   w_wr_addr;

`ifdef SLS_ROW_WRAP_EN
  localparam int NC_W = $clog2(NUM_ROWS + 1);
  logic [NC_W-1:0] r_nchk;
`endif

  assign w_word_last = (r_word == WC_W'(WPR - 1));
  assign w_nonempty  = |r_buf;
  assign w_start_bad = (32'(i_start_row_num) >= 32'(NUM_ROWS));
  assign w_rd_addr   = ADDR_W'(r_row) * ADDR_W'(WPR)
                     + ADDR_W'(r_word);
  assign w_wr_addr   = WR_BASE + ADDR_W'(r_word);
  assign o_done      = (r_state == DONE);

  // Next row to search and whether the current row ends the search
  always_comb begin
    w_row_nxt  = r_row;
    w_row_last = 1'b0;
`ifdef SLS_ROW_WRAP_EN
    w_row_last = (r_nchk == NC_W'(NUM_ROWS - 1));
    if (r_dir)
      w_row_nxt = (r_row == '0) ? ROW_W'(NUM_ROWS - 1)
                                : r_row - ROW_W'(1);
    else
      w_row_nxt = (r_row == ROW_W'(NUM_ROWS - 1)) ? '0
                                : r_row + ROW_W'(1);
`else
    w_row_last = r_dir ? (r_row == '0)
                       : (r_row == ROW_W'(NUM_ROWS - 1));
    w_row_nxt  = r_dir ? r_row - ROW_W'(1)
                       : r_row + ROW_W'(1);
`endif
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:
        if (i_trig)
          w_state_nxt = w_start_bad ? DONE : RD_REQ;
      RD_REQ:  w_state_nxt = RD_WAIT;
      RD_WAIT:
        if (i_rd_from_bram_done)
          w_state_nxt = w_word_last ? CHECK : RD_REQ;
      CHECK:
        if (w_nonempty)      w_state_nxt = WR_REQ;
        else if (w_row_last) w_state_nxt = DONE;
        else                 w_state_nxt = RD_REQ;
      WR_REQ:  w_state_nxt = WR_WAIT;
      WR_WAIT:
        if (i_wr_to_bram_done)
          w_state_nxt = w_word_last ? DONE : WR_REQ;
      DONE:
        if (!i_trig) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: row/word counters, assembly buffer, bus and result regs
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_row               <= '0;
      r_dir               <= 1'b0;
      r_word              <= '0;
      r_buf               <= '0;
      o_rd_from_bram_addr <= '0;
      o_rd_from_bram_trig <= 1'b0;
      o_wr_to_bram_addr   <= '0;
      o_wr_to_bram_data   <= '0;
      o_wr_to_bram_trig   <= 1'b0;
      o_row_mask          <= '0;
      o_found_row         <= '0;
      o_found             <= 1'b0;
`ifdef SLS_ROW_WRAP_EN
      r_nchk              <= '0;
`endif
    end else begin
      unique case (r_state)
        IDLE:
          if (i_trig) begin
            r_row       <= i_start_row_num;
            r_dir       <= i_dir;
            r_word      <= '0;
            r_buf       <= '0;
            o_found     <= 1'b0;
            o_found_row <= '0;
            o_row_mask  <= '0;
`ifdef SLS_ROW_WRAP_EN
            r_nchk      <= '0;
`endif
          end
        RD_REQ: begin
          o_rd_from_bram_trig <= 1'b1;
          o_rd_from_bram_addr <= w_rd_addr;
        end
        RD_WAIT:
          if (i_rd_from_bram_done) begin
            o_rd_from_bram_trig <= 1'b0;
            r_buf[r_word*WORD_W +: WORD_W] <= i_rd_from_bram_data;
            r_word <= w_word_last ? '0 : r_word + WC_W'(1);
          end
        CHECK:
          if (w_nonempty) begin
            o_found     <= 1'b1;
            o_found_row <= r_row;
            o_row_mask  <= r_buf;
          end else if (!w_row_last) begin
            r_row  <= w_row_nxt;
            r_buf  <= '0;
`ifdef SLS_ROW_WRAP_EN
            r_nchk <= r_nchk + NC_W'(1);
`endif
          end
        WR_REQ: begin
          o_wr_to_bram_trig <= 1'b1;
          o_wr_to_bram_addr <= w_wr_addr;
          o_wr_to_bram_data <= o_row_mask[r_word*WORD_W +: WORD_W];
        end
        WR_WAIT:
          if (i_wr_to_bram_done) begin
            o_wr_to_bram_trig <= 1'b0;
            r_word <= w_word_last ? '0 : r_word + WC_W'(1);
          end
        default: ;
      endcase
    end
  end

endmodule
